// File: rtl/clock_set_ctrl.sv
// Menu/edit sequencer for the HH:MM:SS clock, clocked by the 1 kHz display tick.
// Turns debounced key levels into a 5-mode edit FSM that owns the time-set values
// and load strobe, the alarm registers, the pause toggle and the per-field blink.
module clock_set_ctrl #(
  parameter int unsigned HOLD_CYC     = 1000,
  parameter int unsigned RPT_CYC      = 200,
  parameter int unsigned BLINK_HALF   = 500,
  parameter int unsigned TIMEOUT_CYC  = 10000,
  parameter int unsigned ALARM_HR_RST = 7,
  parameter int unsigned ALARM_MN_RST = 0
) (
  input  logic       clk_shuma,
  input  logic       rst,
  input  logic       key_mode_i,
  input  logic       key_inc_i,
  input  logic       key_dec_i,
  input  logic       key_pause_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  output logic [2:0] mode_o,
  output logic [4:0] edit_hour_o,
  output logic [5:0] edit_min_o,
  output logic       time_load_o,
  output logic [4:0] alarm_hour_o,
  output logic [5:0] alarm_min_o,
  output logic       pause_o,
  output logic       disp_alarm_o,
  output logic [3:0] digit_blank_o
);

  // All timer limits must fit in 16 bits.
  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] HoldLim  = CntW'(HOLD_CYC);
  localparam logic [CntW-1:0] RptLim   = CntW'(RPT_CYC);
  localparam logic [CntW-1:0] BlinkLim = CntW'(BLINK_HALF);
  localparam logic [CntW-1:0] TmoLim   = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [4:0]      AlHrRst  = 5'(ALARM_HR_RST);
  localparam logic [5:0]      AlMnRst  = 6'(ALARM_MN_RST);

  // Key bit positions inside the synchronizer vectors.
  localparam int unsigned KMode  = 0;
  localparam int unsigned KInc   = 1;
  localparam int unsigned KDec   = 2;
  localparam int unsigned KPause = 3;

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StSetHr  = 3'd1,
    StSetMin = 3'd2,
    StAlHr   = 3'd3,
    StAlMin  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      key_s1_q, key_s2_q, key_s3_q;
  logic [3:0]      key_rise;
  logic [4:0]      edit_hour_q, edit_hour_d, alarm_hour_q, alarm_hour_d;
  logic [5:0]      edit_min_q, edit_min_d, alarm_min_q, alarm_min_d;
  logic            time_load_q, time_load_d;
  logic            pause_q, pause_d;
  logic            rpt_act_q, rpt_act_d, rpt_up_q, rpt_up_d, rpt_fast_q, rpt_fast_d;
  logic [CntW-1:0] hold_q, hold_d, hold_nxt;
  logic [CntW-1:0] tmo_q, tmo_d, tmo_nxt;
  logic [CntW-1:0] blink_cnt_q, blink_cnt_d, blink_nxt;
  logic            blink_q, blink_d;
  logic            step, step_up, held, in_edit;

  function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
    if (up) return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
    if (up) return (m >= 6'd59) ? 6'd0 : m + 6'd1;
    return (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  assign key_rise = key_s2_q & ~key_s3_q;
  assign in_edit  = (state_q != StRun);

  // Two-flop synchronizer plus one delay stage for rising-edge detection.
  always_ff @(posedge clk_shuma or negedge rst) begin
    if (!rst) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      key_s3_q <= '0;
    end else begin
      key_s1_q <= {key_pause_i, key_dec_i, key_inc_i, key_mode_i};
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
    end
  end

  // State, value registers and timers.
  always_ff @(posedge clk_shuma or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      edit_hour_q  <= '0;
      edit_min_q   <= '0;
      alarm_hour_q <= AlHrRst;
      alarm_min_q  <= AlMnRst;
      time_load_q  <= 1'b0;
      pause_q      <= 1'b0;
      rpt_act_q    <= 1'b0;
      rpt_up_q     <= 1'b0;
      rpt_fast_q   <= 1'b0;
      hold_q       <= '0;
      tmo_q        <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      edit_hour_q  <= edit_hour_d;
      edit_min_q   <= edit_min_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      time_load_q  <= time_load_d;
      pause_q      <= pause_d;
      rpt_act_q    <= rpt_act_d;
      rpt_up_q     <= rpt_up_d;
      rpt_fast_q   <= rpt_fast_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
    end
  end

  // Key arbitration, auto-repeat, mode FSM, timeout and blink next-state.
  always_comb begin
    state_d      = state_q;
    edit_hour_d  = edit_hour_q;
    edit_min_d   = edit_min_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    time_load_d  = 1'b0;
    pause_d      = pause_q;
    rpt_act_d    = rpt_act_q;
    rpt_up_d     = rpt_up_q;
    rpt_fast_d   = rpt_fast_q;
    hold_d       = hold_q;
    tmo_d        = tmo_q;
    blink_cnt_d  = blink_cnt_q;
    blink_d      = blink_q;
    step         = 1'b0;
    step_up      = 1'b0;
    held         = rpt_up_q ? key_s2_q[KInc] : key_s2_q[KDec];
    hold_nxt     = (hold_q == CntMax) ? hold_q : hold_q + CntOne;
    tmo_nxt      = tmo_q + CntOne;
    blink_nxt    = blink_cnt_q + CntOne;

    // Mode beats a step; inc+dec cancel each other; any other edge kills repeat.
    if (key_rise[KMode] || (key_rise[KInc] && key_rise[KDec])) begin
      rpt_act_d = 1'b0;
      hold_d    = '0;
    end else if (key_rise[KInc] || key_rise[KDec]) begin
      step       = 1'b1;
      step_up    = key_rise[KInc];
      rpt_act_d  = 1'b1;
      rpt_up_d   = key_rise[KInc];
      rpt_fast_d = 1'b0;
      hold_d     = '0;
    end else if (key_rise[KPause]) begin
      rpt_act_d = 1'b0;
      hold_d    = '0;
    end else if (rpt_act_q) begin
      if (!held) begin
        rpt_act_d = 1'b0;
        hold_d    = '0;
      end else if (hold_nxt == (rpt_fast_q ? RptLim : HoldLim)) begin
        step       = 1'b1;
        step_up    = rpt_up_q;
        rpt_fast_d = 1'b1;
        hold_d     = '0;
      end else begin
        hold_d = hold_nxt;
      end
    end

    if (key_rise[KMode]) begin
      case (state_q)
        StRun: begin
          state_d     = StSetHr;
          edit_hour_d = cur_hour_i;
          edit_min_d  = cur_min_i;
        end
        StSetHr:  state_d = StSetMin;
        StSetMin: begin
          state_d     = StAlHr;
          time_load_d = 1'b1;
        end
        StAlHr:   state_d = StAlMin;
        default:  state_d = StRun;
      endcase
    end else if (step) begin
      case (state_q)
        StSetHr:  edit_hour_d  = hour_step(edit_hour_q, step_up);
        StSetMin: edit_min_d   = min_step(edit_min_q, step_up);
        StAlHr:   alarm_hour_d = hour_step(alarm_hour_q, step_up);
        StAlMin:  alarm_min_d  = min_step(alarm_min_q, step_up);
        default:  ;
      endcase
    end

    // Abort to RUN after a quiet period; pending time edit is dropped (no load).
    if ((|key_rise) || !in_edit) begin
      tmo_d = '0;
    end else if (tmo_nxt == TmoLim) begin
      state_d = StRun;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_nxt;
    end

    if (key_rise[KPause] && (state_q == StRun)) begin
      pause_d = ~pause_q;
    end

    // A step forces the edited field visible so the user sees the new value.
    if (!in_edit || step) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_nxt == BlinkLim) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_nxt;
    end
  end

  // Blank the field pair under edit according to the blink phase.
  always_comb begin
    digit_blank_o = 4'b0000;
    case (state_q)
      StSetHr, StAlHr:   digit_blank_o = {blink_q, blink_q, 2'b00};
      StSetMin, StAlMin: digit_blank_o = {2'b00, blink_q, blink_q};
      default:           digit_blank_o = 4'b0000;
    endcase
  end

  assign mode_o       = state_q;
  assign edit_hour_o  = edit_hour_q;
  assign edit_min_o   = edit_min_q;
  assign time_load_o  = time_load_q;
  assign alarm_hour_o = alarm_hour_q;
  assign alarm_min_o  = alarm_min_q;
  assign pause_o      = pause_q;
  assign disp_alarm_o = (state_q == StAlHr) || (state_q == StAlMin);

endmodule
